// File: rtl/spart_tx_bus_if.sv
// -----------------------------------------------------------------------------
// spart_tx_bus_if
// Bus-cycle control signals from the processor-side driver to the SPART.
//   iocs    chip select
//   iorw    1 = read (SPART drives databus), 0 = write (driver drives databus)
//   ioaddr  register select: 00 data, 01 status, 10 DBL, 11 DBH
// The 8-bit databus is a resolved tristate net and stays a plain inout port on
// the slave so that both ends can release it to high-Z.
// -----------------------------------------------------------------------------
interface spart_tx_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (output iocs, output iorw, output ioaddr);
  modport slave  (input  iocs, input  iorw, input  ioaddr);
endinterface

// File: rtl/spart_tx_bus.sv
// -----------------------------------------------------------------------------
// spart_tx_bus
// SPART bus slave: decodes driver bus cycles, holds the 16-bit baud divisor
// (DBH:DBL), generates the 16x baud enable and serialises transmit bytes onto
// txd as 8N1 frames (8E1-style with an extra parity bit when SPART_PARITY_EN
// is defined).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   bus      iocs/iorw/ioaddr from the driver (slave modport)
//   databus  shared 8-bit bus, driven only on reads with iocs=1
//   rx_data  received byte from the receiver block
//   rx_rda   receiver holds an unread byte
//   rx_ack   one-cycle read acknowledge to the receiver (combinational)
//   rda      pass-through of rx_rda
//   tbr      transmit buffer ready
//   txd      serial output, idles high
//   baud_en  16x oversample tick, shared with the receiver
//
// Optional feature macro: SPART_PARITY_EN (adds an even-parity bit before stop
// and sets status bit 2).
// -----------------------------------------------------------------------------
module spart_tx_bus #(
  parameter logic [15:0] DIV_RESET  = 16'h028B,
  parameter int          OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst,
  spart_tx_bus_if.slave   bus,
  inout  wire  [7:0]      databus,
  input  logic [7:0]      rx_data,
  input  logic            rx_rda,
  output logic            rx_ack,
  output logic            rda,
  output logic            tbr,
  output logic            txd,
  output logic            baud_en
);

  localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

`ifdef SPART_PARITY_EN
  localparam logic PARITY_BUILT_IN = 1'b1;
`else
  localparam logic PARITY_BUILT_IN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic [7:0]    dbl_r;
  logic [7:0]    dbh_r;
  logic [15:0]   baud_cnt_r;
  logic          baud_en_r;
  tx_state_t     state_r;
  logic          tbr_r;
  logic          txd_r;
  logic [TW-1:0] tick_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          par_r;

  logic          wr_s;
  logic          rd_s;
  logic          div_wr_s;
  logic          tx_wr_s;
  logic [15:0]   new_div_s;
  logic [7:0]    rd_data_s;

  assign wr_s     = bus.iocs & ~bus.iorw;
  assign rd_s     = bus.iocs &  bus.iorw;
  assign div_wr_s = wr_s & bus.ioaddr[1];
  // A tx write is only taken while the buffer is free; this also drops a write
  // that lands on the same edge as stop-bit completion.
  assign tx_wr_s  = wr_s & (bus.ioaddr == 2'b00) & tbr_r;

  // Divisor value as it will be after this cycle's write, so the counter
  // reloads with the byte being written rather than the stale one.
  always_comb begin
    if (bus.ioaddr[0]) begin
      new_div_s = {databus, dbl_r};
    end else begin
      new_div_s = {dbh_r, databus};
    end
  end

  // Read mux for the shared bus.
  always_comb begin
    case (bus.ioaddr)
      2'b00:   rd_data_s = rx_data;
      2'b01:   rd_data_s = {5'b0_0000, PARITY_BUILT_IN, tbr_r, rx_rda};
      2'b10:   rd_data_s = dbl_r;
      2'b11:   rd_data_s = dbh_r;
      default: rd_data_s = 8'h00;
    endcase
  end

  assign databus = rd_s ? rd_data_s : 8'bzzzz_zzzz;
  assign rx_ack  = rd_s & (bus.ioaddr == 2'b00) & rx_rda;
  assign rda     = rx_rda;
  assign tbr     = tbr_r;
  assign txd     = txd_r;
  assign baud_en = baud_en_r;

  // Divisor registers and baud down-counter; a zero count emits one tick and
  // reloads, so a divisor of 0 ticks every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbl_r      <= DIV_RESET[7:0];
      dbh_r      <= DIV_RESET[15:8];
      baud_cnt_r <= DIV_RESET;
      baud_en_r  <= 1'b0;
    end else if (div_wr_s) begin
      if (bus.ioaddr[0]) begin
        dbh_r <= databus;
      end else begin
        dbl_r <= databus;
      end
      baud_cnt_r <= new_div_s;
      baud_en_r  <= 1'b0;
    end else if (baud_cnt_r == 16'd0) begin
      baud_cnt_r <= {dbh_r, dbl_r};
      baud_en_r  <= 1'b1;
    end else begin
      baud_cnt_r <= baud_cnt_r - 16'd1;
      baud_en_r  <= 1'b0;
    end
  end

  // Transmit FSM: each frame bit lasts OVERSAMPLE baud ticks; the start bit
  // is driven on the accepting edge so txd falls one clock after the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      tbr_r   <= 1'b1;
      txd_r   <= 1'b1;
      tick_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      par_r   <= 1'b0;
    end else if (tx_wr_s) begin
      state_r <= START;
      tbr_r   <= 1'b0;
      txd_r   <= 1'b0;
      tick_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= databus;
      par_r   <= even_parity(databus);
    end else if (baud_en_r) begin
      case (state_r)
        IDLE: begin
          txd_r <= 1'b1;
        end
        START: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= DATA;
            txd_r   <= shift_r[0];
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        DATA: begin
          if (tick_r == TICK_LAST) begin
            tick_r <= '0;
            if (bit_r == 3'd7) begin
`ifdef SPART_PARITY_EN
              state_r <= PARITY;
              txd_r   <= par_r;
`else
              state_r <= STOP;
              txd_r   <= 1'b1;
`endif
            end else begin
              bit_r   <= bit_r + 3'd1;
              shift_r <= {1'b0, shift_r[7:1]};
              txd_r   <= shift_r[1];
            end
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
`ifdef SPART_PARITY_EN
        PARITY: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= STOP;
            txd_r   <= 1'b1;
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= IDLE;
            tbr_r   <= 1'b1;
          end else begin
            tick_r <= tick_r + TW'(1);
          end
          txd_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          tbr_r   <= 1'b1;
          txd_r   <= 1'b1;
          tick_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx_bus.sv
// -----------------------------------------------------------------------------
// tb_spart_tx_bus
// Self-checking bench for spart_tx_bus: register access, receive handshake,
// baud period and serial frames with random bytes and divisors, compared with
// a frame model built from start/data/parity/stop bit rules.
// -----------------------------------------------------------------------------
module tb_spart_tx_bus;

  localparam int OS = 16;
`ifdef SPART_PARITY_EN
  localparam int   NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int   NB  = 10;
  localparam logic PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] drv;
  logic       drv_en;
  logic [7:0] rx_data;
  logic       rx_rda;
  logic       rx_ack;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       baud_en;
  wire  [7:0] databus;

  int checks;
  int failures;

  spart_tx_bus_if bus_if ();

  assign databus = drv_en ? drv : 8'bzzzz_zzzz;

  spart_tx_bus dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .databus (databus),
    .rx_data (rx_data),
    .rx_rda  (rx_rda),
    .rx_ack  (rx_ack),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .baud_en (baud_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected line level for frame bit idx: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
    if (PAR && idx == 9) return ^v;
    return 1'b1;
  endfunction

  task automatic bus_idle();
    bus_if.iocs = 1'b0;
    bus_if.iorw = 1'b0;
    drv_en      = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = a;
    drv = d; drv_en = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  // Read with a simple receiver model: rx_rda clears on the edge after an ack.
  task automatic bus_read(input logic [1:0] a, output logic [7:0] d,
                          output logic ack0, output logic ack1);
    @(negedge clk);
    drv_en = 1'b0;
    bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = a;
    #1;
    d = databus; ack0 = rx_ack;
    @(posedge clk);
    if (ack0) rx_rda = 1'b0;
    @(negedge clk);
    ack1 = rx_ack;
    bus_idle();
  endtask

  task automatic set_div(input logic [15:0] v);
    bus_write(2'b10, v[7:0]);
    bus_write(2'b11, v[15:8]);
  endtask

  task automatic measure_period(output int per);
    int n;
    n = 0;
    @(negedge clk);
    while (!baud_en && n < 5000) begin @(negedge clk); n++; end
    per = 0;
    do begin @(negedge clk); per++; end while (!baud_en && per < 5000);
  endtask

  // Send byte b and check every baud tick of the frame. Optionally issue a
  // second tx write at tick intr_tick, or pull reset at tick rst_tick.
  task automatic run_frame(input logic [7:0] b, input int gap, input int intr_tick,
                           input logic [7:0] intr_b, input int rst_tick);
    int  ticks, clks, last, iter;
    logic rel;
    bus_write(2'b00, b);
    chk("tbr_busy", 32'(tbr), 32'h0);
    chk("txd_start", 32'(txd), 32'h0);
    ticks = 0; clks = 0; last = 0; iter = 0; rel = 1'b0;
    while (ticks < NB*OS && iter < 20000) begin
      if (rel) begin bus_idle(); rel = 1'b0; end
      if (baud_en) begin
        if (ticks > 0) chk("tick_gap", clks - last, gap);
        last = clks;
        chk($sformatf("txd_t%0d", ticks), 32'(txd), 32'(exp_bit(b, ticks / OS)));
        if (ticks == rst_tick) begin
          rst = 1'b0;
          #1;
          chk("rst_txd", 32'(txd), 32'h1);
          chk("rst_tbr", 32'(tbr), 32'h1);
          @(negedge clk);
          rst = 1'b1;
          return;
        end
        if (ticks == intr_tick) begin
          bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00;
          drv = intr_b; drv_en = 1'b1; rel = 1'b1;
        end
        ticks++;
      end
      if (ticks < NB*OS) begin
        @(negedge clk); clks++; iter++;
      end
    end
    if (iter >= 20000) chk("frame_timeout", ticks, NB*OS);
    @(negedge clk);
    if (rel) bus_idle();
    chk("tbr_done", 32'(tbr), 32'h1);
    chk("txd_idle", 32'(txd), 32'h1);
  endtask

  initial begin
    logic [7:0] d;
    logic       a0, a1;
    int         per;
    int         dv;
    checks = 0; failures = 0;
    rst = 1'b0; drv = 8'h00; drv_en = 1'b0; rx_data = 8'h00; rx_rda = 1'b0;
    bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tbr", 32'(tbr), 32'h1);
    chk("rst_txd", 32'(txd), 32'h1);
    chk("rst_baud_en", 32'(baud_en), 32'h0);

    // Bus released while deselected: a read of DBL must not appear.
    bus_if.iorw = 1'b1; bus_if.ioaddr = 2'b10;
    #1;
    chk("hiz_iocs0", 32'(databus !== 8'h8B), 32'h1);
    chk("ack_iocs0", 32'(rx_ack), 32'h0);
    bus_idle();

    bus_read(2'b10, d, a0, a1); chk("rst_dbl", 32'(d), 32'h8B);
    bus_read(2'b11, d, a0, a1); chk("rst_dbh", 32'(d), 32'h02);

    rx_rda = 1'b1;
    bus_read(2'b01, d, a0, a1);
    chk("status_idle", 32'(d), 32'({5'b0, PAR, 1'b1, 1'b1}));
    chk("rda_pass", 32'(rda), 32'h1);

    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom);
      rx_rda  = 1'b1;
      bus_read(2'b00, d, a0, a1);
      chk("rx_data", 32'(d), 32'(rx_data));
      chk("rx_ack_on", 32'(a0), 32'h1);
      chk("rx_ack_once", 32'(a1), 32'h0);
    end
    chk("rda_cleared", 32'(rda), 32'h0);
    bus_read(2'b00, d, a0, a1);
    chk("rx_ack_none", 32'(a0), 32'h0);

    set_div(16'h0516);
    bus_read(2'b10, d, a0, a1); chk("dbl_rd", 32'(d), 32'h16);
    bus_read(2'b11, d, a0, a1); chk("dbh_rd", 32'(d), 32'h05);
    measure_period(per);
    chk("baud_period", per, 32'h0517);

    // Deselected write and status write leave registers alone.
    @(negedge clk);
    bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b10;
    drv = 8'h77; drv_en = 1'b1;
    @(negedge clk);
    bus_idle();
    bus_read(2'b10, d, a0, a1); chk("dbl_no_iocs", 32'(d), 32'h16);
    bus_write(2'b01, 8'hFF);
    bus_read(2'b01, d, a0, a1);
    chk("status_wr_ign", 32'(d), 32'({5'b0, PAR, 1'b1, 1'b0}));

    set_div(16'h0001);
    run_frame(8'hA5, 2, 40, 8'h3C, -1);
    run_frame(8'h5A, 2, NB*OS - 1, 8'hC3, -1);

    for (int i = 0; i < 3; i++) begin
      dv = int'($urandom_range(0, 3));
      set_div(16'(dv));
      run_frame(8'($urandom), dv + 1, -1, 8'h00, -1);
    end

    set_div(16'h0001);
    run_frame(8'hA5, 2, -1, 8'h00, 40);
    bus_read(2'b10, d, a0, a1); chk("rst_mid_dbl", 32'(d), 32'h8B);
    set_div(16'h0001);
    run_frame(8'($urandom), 2, -1, 8'h00, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
